// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot loader: sync byte, framing FSM and UART bit FSM encodings.
package imem_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    localparam logic [2:0] LD_IDLE   = 3'd0;
    localparam logic [2:0] LD_CNT_LO = 3'd1;
    localparam logic [2:0] LD_CNT_HI = 3'd2;
    localparam logic [2:0] LD_DATA   = 3'd3;
    localparam logic [2:0] LD_DONE   = 3'd4;
    localparam logic [2:0] LD_ERR    = 3'd5;

    localparam logic [2:0] RX_IDLE    = 3'd0;
    localparam logic [2:0] RX_START   = 3'd1;
    localparam logic [2:0] RX_DATA    = 3'd2;
    localparam logic [2:0] RX_STOP    = 3'd3;
    localparam logic [2:0] RX_CLEANUP = 3'd4;

    // An image longer than the word-addressable imem would wrap onto itself.
    function automatic logic cnt_overflows(input logic [15:0] n, input int addr_width);
        return 32'(n) > (32'd1 << (addr_width - 2));
    endfunction

    function automatic logic is_loading(input logic [2:0] st);
        return (st == LD_CNT_LO) || (st == LD_CNT_HI) || (st == LD_DATA);
    endfunction

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: double-flop synchroniser, mid-bit start qualification, centre sampling.
// Latency: byte_valid / frame_err pulse at the stop-bit centre.
// Backpressure: none; a byte is a single-cycle strobe and must be consumed when presented.
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_BIT) begin
                        clk_cnt  <= '0;
                        // A glitch that is gone by mid-bit is not a start bit.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_BIT) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == FULL_BIT) begin
                        clk_cnt    <= '0;
                        byte_valid <= rx_s;
                        frame_err  <= !rx_s;
                        rx_state   <= RX_CLEANUP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_CLEANUP: begin
                    // After a low stop bit, wait for the line to return high before hunting.
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_out = shreg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed UART image -> 32-bit imem writes; holds the CPU in reset until the image lands.
// Latency: final stop-bit centre -> imem_we 1 cycle; final imem_we -> cpu_rst low 1 cycle.
// Backpressure: none; imem must accept a write every cycle imem_we is high.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 16,
    parameter int WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_serial,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [WIDTH-1:0]      imem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  err
);

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    logic                  frame_err;

    logic [2:0]            state;
    logic [15:0]           cnt_rem;
    logic [1:0]            idx;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [23:0]           lane_buf;
    logic [15:0]           hdr_cnt;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .byte_out   (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // The low count byte is parked in cnt_rem[7:0] until the high byte arrives.
    assign hdr_cnt = {rx_byte, cnt_rem[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LD_IDLE;
            cnt_rem    <= '0;
            idx        <= '0;
            word_addr  <= '0;
            lane_buf   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (state == LD_DONE) begin
                cpu_rst <= 1'b0;
                busy    <= 1'b0;
            end

            if (frame_err && is_loading(state)) begin
                state <= LD_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
            end else if (byte_valid) begin
                case (state)
                    LD_IDLE, LD_DONE, LD_ERR: begin
                        if (rx_byte == LOADER_SYNC) begin
                            state   <= LD_CNT_LO;
                            err     <= 1'b0;
                            cpu_rst <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    LD_CNT_LO: begin
                        cnt_rem[7:0] <= rx_byte;
                        state        <= LD_CNT_HI;
                    end
                    LD_CNT_HI: begin
                        if (hdr_cnt == 16'd0) begin
                            state <= LD_DONE;
                        end else if (cnt_overflows(hdr_cnt, ADDR_WIDTH)) begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= LD_DATA;
                            cnt_rem   <= hdr_cnt;
                            idx       <= 2'd0;
                            word_addr <= '0;
                        end
                    end
                    LD_DATA: begin
                        idx <= idx + 1'b1;
                        case (idx)
                            2'd0: lane_buf[7:0]   <= rx_byte;
                            2'd1: lane_buf[15:8]  <= rx_byte;
                            2'd2: lane_buf[23:16] <= rx_byte;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= WIDTH'({rx_byte, lane_buf});
                                imem_waddr <= word_addr;
                                word_addr  <= word_addr + ADDR_WIDTH'(4);
                                cnt_rem    <= cnt_rem - 1'b1;
                                if (cnt_rem == 16'd1) state <= LD_DONE;
                            end
                        endcase
                    end
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: directed UART frames, expected imem writes queued ahead of stimulus.
module tb_imem_loader;

    localparam int CPB = 8;
    localparam int AW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_serial;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW),
        .WIDTH        (32)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .err        (err)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wr_count = 0;
    int  last_we_cyc = -100;
    int  rst_fall_cyc = -1;
    int  rst_rise_cyc = -1;
    int  busy_fall_cyc = -1;
    int  bv_cyc = -1;
    int  w0;
    logic prev_cpu_rst = 1'b1;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe and timestamps control edges.
    always @(negedge clk) begin
        cyc++;
        if (imem_we === 1'b1) begin
            wr_count++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h expected=none", imem_waddr, imem_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_waddr), 32'(exp_e.addr));
                check("wr_data", imem_wdata, exp_e.data);
            end
        end
        if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) rst_fall_cyc = cyc;
        if (prev_cpu_rst === 1'b0 && cpu_rst === 1'b1) rst_rise_cyc = cyc;
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        if (u_dut.byte_valid === 1'b1) bv_cyc = cyc;
        prev_cpu_rst = cpu_rst;
        prev_busy    = busy;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(8'hA5, 1'b1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [15:0] addr, input logic [31:0] w);
        exp_q.push_back('{addr: addr, data: w});
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], 1'b1);
    endtask

    task automatic check_released(input string tag);
        check({tag, "_rel_lat"}, 32'(rst_fall_cyc - last_we_cyc), 32'd1);
        check({tag, "_busy_fall"}, 32'(busy_fall_cyc), 32'(rst_fall_cyc));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: two-word image
        w0 = wr_count;
        send_hdr(16'd2);
        check("t1_busy", 32'(busy), 32'd1);
        send_word(16'h0000, 32'h00A0_0093);
        send_word(16'h0004, 32'hDEAD_BEEF);
        check_released("t1");
        check("t1_writes", 32'(wr_count - w0), 32'd2);

        // 2: noise ignored while DONE, then a one-word load
        w0 = wr_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        check("t2_noise_busy", 32'(busy), 32'd0);
        check("t2_noise_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t2_noise_writes", 32'(wr_count - w0), 32'd0);
        send_hdr(16'd1);
        send_word(16'h0000, 32'h1234_5678);
        check_released("t2");

        // 3: empty image, then an oversized count
        w0 = wr_count;
        send_hdr(16'h0000);
        check("t3_zero_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t3_zero_busy", 32'(busy), 32'd0);
        check("t3_zero_writes", 32'(wr_count - w0), 32'd0);
        send_hdr(16'h4001);
        check("t3_ovf_err", 32'(err), 32'd1);
        check("t3_ovf_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t3_ovf_busy", 32'(busy), 32'd0);

        // 4: bad stop bit on 3rd data byte, then recovery
        w0 = wr_count;
        send_hdr(16'd2);
        check("t4_err_cleared", 32'(err), 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        check("t4_frame_err", 32'(err), 32'd1);
        check("t4_frame_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t4_frame_writes", 32'(wr_count - w0), 32'd0);
        send_hdr(16'd1);
        check("t4_resync_err", 32'(err), 32'd0);
        send_word(16'h0000, 32'hCAFE_F00D);
        check_released("t4");

        // 5: reload without board reset
        send_byte(8'hA5, 1'b1);
        check("t5_rise_lat", 32'(rst_rise_cyc - bv_cyc), 32'd1);
        check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(16'h0000, 32'h0BAD_C0DE);
        check_released("t5");

        // 6: reset mid-image after five data bytes
        send_hdr(16'd3);
        send_word(16'h0000, 32'h8765_4321);
        send_byte(8'h99, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_we", 32'(imem_we), 32'd0);
        check("t6_waddr", 32'(imem_waddr), 32'd0);
        check("t6_wdata", imem_wdata, 32'd0);
        check("t6_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_hdr(16'd1);
        send_word(16'h0000, 32'h55AA_33CC);
        check_released("t6");

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
